// File: rtl/la_pwrseq.sv
// la_pwrseq -- power-domain sequencer.
//
// Brings a switchable power domain up and down in a fixed, safe order:
//   up:   enable switch -> wait for rail good -> settle dwell ->
//         release domain reset -> guard dwell -> drop isolation (ON)
//   down: raise isolation -> guard dwell -> assert domain reset ->
//         disable switch -> wait for rail to drop (OFF)
// A missing switch acknowledge (either direction) for TOUT cycles parks the
// sequencer in FAULT. Only reset leaves FAULT.
//
// Ports
//   clk        : single clock
//   reset      : synchronous, active-high
//   pwr_req    : 1 = domain requested on, 0 = requested off
//   psw_ack    : power switch status, 1 = rail good
//   cfg_settle : rail settle dwell (SETTLE lasts cfg_settle+1 cycles)
//   cfg_iso    : isolation/reset guard dwell (UNRST and ISO last cfg_iso+1)
//   iso        : isolation enable (to la_isohi iso pins)
//   psw_en     : power switch enable
//   dom_reset  : active-high domain reset
//   ready      : domain powered, released and de-isolated
//   busy       : a sequence is in progress
//   fault      : acknowledge timeout occurred (sticky until reset)
//   state_dbg  : current FSM state encoding, for observation only
//
// Handshake: there is no valid/ready pair here. pwr_req is a level that is
// only looked at in OFF and ON; while busy=1 it is ignored, and a request
// that disagrees with the state reached is acted on the following cycle.
//
// All outputs are registered and decoded from the next state, so they always
// correspond to the registered state (Moore behaviour, no input-to-output
// combinational path).
module la_pwrseq #(
  parameter        PROP = "DEFAULT",
  parameter int    CW   = 8,
  parameter int    TOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pwr_req,
  input  logic          psw_ack,
  input  logic [CW-1:0] cfg_settle,
  input  logic [CW-1:0] cfg_iso,
  output logic          iso,
  output logic          psw_en,
  output logic          dom_reset,
  output logic          ready,
  output logic          busy,
  output logic          fault,
  output logic [3:0]    state_dbg
);

  typedef enum logic [3:0] {
    S_OFF    = 4'd0,
    S_PWRUP  = 4'd1,
    S_SETTLE = 4'd2,
    S_UNRST  = 4'd3,
    S_ON     = 4'd4,
    S_ISO    = 4'd5,
    S_RST    = 4'd6,
    S_PWRDN  = 4'd7,
    S_FAULT  = 4'd8
  } state_t;

  // Counter value on the last allowed cycle of an acknowledge wait.
  localparam logic [CW-1:0] TOUT_LAST = CW'(TOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          iso_q, iso_d;
  logic          psw_en_q, psw_en_d;
  logic          dom_reset_q, dom_reset_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:    if (pwr_req) state_d = S_PWRUP;
      S_PWRUP: begin
        if (psw_ack)                 state_d = S_SETTLE;
        else if (cnt_q == TOUT_LAST) state_d = S_FAULT;
      end
      S_SETTLE: if (cnt_q == cfg_settle) state_d = S_UNRST;
      S_UNRST:  if (cnt_q == cfg_iso)    state_d = S_ON;
      S_ON:     if (!pwr_req)            state_d = S_ISO;
      S_ISO:    if (cnt_q == cfg_iso)    state_d = S_RST;
      S_RST:    state_d = S_PWRDN;
      S_PWRDN: begin
        if (!psw_ack)                state_d = S_OFF;
        else if (cnt_q == TOUT_LAST) state_d = S_FAULT;
      end
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_OFF;
    endcase

    // Shared dwell counter: restarts at 0 on every state entry. It may wrap
    // in the unbounded states (OFF, ON, FAULT) where it is never compared.
    if (state_d != state_q) cnt_d = '0;
    else                    cnt_d = cnt_q + CW'(1);

    // Output decode of the state being entered; iso is only ever 0 in ON,
    // where the switch is on and the domain reset is released.
    iso_d       = 1'b1;
    psw_en_d    = 1'b1;
    dom_reset_d = 1'b1;
    ready_d     = 1'b0;
    busy_d      = 1'b1;
    fault_d     = 1'b0;
    case (state_d)
      S_OFF:    begin psw_en_d = 1'b0; busy_d = 1'b0; end
      S_PWRUP:  ;
      S_SETTLE: ;
      S_UNRST:  dom_reset_d = 1'b0;
      S_ON:     begin iso_d = 1'b0; dom_reset_d = 1'b0; ready_d = 1'b1; busy_d = 1'b0; end
      S_ISO:    dom_reset_d = 1'b0;
      S_RST:    ;
      S_PWRDN:  psw_en_d = 1'b0;
      S_FAULT:  begin psw_en_d = 1'b0; busy_d = 1'b0; fault_d = 1'b1; end
      default:  begin psw_en_d = 1'b0; busy_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      iso_q       <= 1'b1;
      psw_en_q    <= 1'b0;
      dom_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      iso_q       <= iso_d;
      psw_en_q    <= psw_en_d;
      dom_reset_q <= dom_reset_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
    end
  end

  assign iso       = iso_q;
  assign psw_en    = psw_en_q;
  assign dom_reset = dom_reset_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_la_pwrseq.sv
// Testbench for la_pwrseq (instantiated with TOUT=4).
// Output vectors are packed as {iso, psw_en, dom_reset, ready, busy, fault}.
module tb_la_pwrseq;

  // Expected output patterns per state, from the state output table.
  localparam logic [5:0] O_OFF    = 6'b101000;
  localparam logic [5:0] O_PWRUP  = 6'b111010;
  localparam logic [5:0] O_SETTLE = 6'b111010;
  localparam logic [5:0] O_UNRST  = 6'b110010;
  localparam logic [5:0] O_ON     = 6'b010100;
  localparam logic [5:0] O_ISO    = 6'b110010;
  localparam logic [5:0] O_RST    = 6'b111010;
  localparam logic [5:0] O_PWRDN  = 6'b101010;
  localparam logic [5:0] O_FAULT  = 6'b101001;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pwr_req = 1'b0;
  logic       psw_ack = 1'b0;
  logic [7:0] cfg_settle = 8'd0;
  logic [7:0] cfg_iso = 8'd0;
  logic       iso, psw_en, dom_reset, ready, busy, fault;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  la_pwrseq #(.PROP("DEFAULT"), .CW(8), .TOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pwr_req    (pwr_req),
    .psw_ack    (psw_ack),
    .cfg_settle (cfg_settle),
    .cfg_iso    (cfg_iso),
    .iso        (iso),
    .psw_en     (psw_en),
    .dom_reset  (dom_reset),
    .ready      (ready),
    .busy       (busy),
    .fault      (fault),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [5:0] exp_q[$];
  bit         inv_en = 1'b0;

  typedef struct {
    logic       rst;
    logic       req;
    logic       ack;
    logic [7:0] st;
    logic [7:0] iv;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rq, input logic ak,
                     input logic [7:0] st, input logic [7:0] iv,
                     input logic [5:0] exp);
    vec_t v;
    v.rst = r; v.req = rq; v.ack = ak; v.st = st; v.iv = iv; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, push the expected outputs, then compare
  // 1 time unit after the rising edge.
  task automatic step(input string name, input logic r, input logic rq,
                      input logic ak, input logic [7:0] st,
                      input logic [7:0] iv, input logic [5:0] exp);
    logic [5:0] got;
    logic [5:0] want;
    reset = r; pwr_req = rq; psw_ack = ak; cfg_settle = st; cfg_iso = iv;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    got  = {iso, psw_en, dom_reset, ready, busy, fault};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b (iso,psw_en,dom_reset,ready,busy,fault)",
               name, got, want);
    end
    inv_en = 1'b1;
  endtask

  // Safety invariant every cycle: iso=0 only with psw_en=1 and dom_reset=0.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if (iso !== 1'b1 && !(psw_en === 1'b1 && dom_reset === 1'b0)) begin
        errors++;
        $display("FAIL invariant iso=%b psw_en=%b dom_reset=%b", iso, psw_en, dom_reset);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Power-up with settle=2, iso=1, ack 3 cycles after psw_en.
    add(1, 1, 0, 2, 1, O_OFF);     // reset held, pwr_req already high
    add(1, 1, 0, 2, 1, O_OFF);
    add(0, 1, 0, 2, 1, O_PWRUP);   // edge 1: psw_en rises
    add(0, 1, 0, 2, 1, O_PWRUP);   // edge 2
    add(0, 1, 0, 2, 1, O_PWRUP);   // edge 3
    add(0, 1, 1, 2, 1, O_SETTLE);  // edge 4: ack seen
    add(0, 1, 1, 2, 1, O_SETTLE);  // edge 5
    add(0, 1, 1, 2, 1, O_SETTLE);  // edge 6
    add(0, 1, 1, 2, 1, O_UNRST);   // edge 7: dom_reset falls
    add(0, 1, 1, 2, 1, O_UNRST);   // edge 8
    add(0, 1, 1, 2, 1, O_ON);      // edge 9: iso falls, ready rises
    add(0, 1, 1, 2, 3, O_ON);      // hold ON
    // Power-down with cfg_iso=3.
    add(0, 0, 1, 2, 3, O_ISO);     // edge 1
    add(0, 0, 1, 2, 3, O_ISO);
    add(0, 0, 1, 2, 3, O_ISO);
    add(0, 0, 1, 2, 3, O_ISO);
    add(0, 0, 1, 2, 3, O_RST);     // edge 5: dom_reset rises
    add(0, 0, 1, 2, 3, O_PWRDN);   // edge 6: psw_en drops
    add(0, 0, 1, 2, 3, O_PWRDN);
    add(0, 0, 0, 2, 3, O_OFF);     // ack fell -> OFF
    add(0, 0, 0, 2, 3, O_OFF);
    // pwr_req dropped during SETTLE: sequence completes, ON for one cycle.
    add(0, 1, 0, 2, 1, O_PWRUP);
    add(0, 1, 1, 2, 1, O_SETTLE);
    add(0, 0, 1, 2, 1, O_SETTLE);
    add(0, 0, 1, 2, 1, O_SETTLE);
    add(0, 0, 1, 2, 1, O_UNRST);
    add(0, 0, 1, 2, 1, O_UNRST);
    add(0, 0, 1, 2, 1, O_ON);
    add(0, 0, 1, 2, 1, O_ISO);
    add(0, 1, 1, 2, 1, O_ISO);     // req back high, ignored while busy
    add(0, 1, 1, 2, 1, O_RST);
    add(0, 1, 1, 2, 1, O_PWRDN);
    add(0, 1, 0, 2, 1, O_OFF);
    add(0, 1, 0, 2, 1, O_PWRUP);   // pending request acted on next cycle
    add(0, 0, 1, 0, 0, O_SETTLE);  // now zero dwells
    add(0, 0, 1, 0, 0, O_UNRST);   // SETTLE lasted 1 cycle
    add(0, 0, 1, 0, 0, O_ON);      // UNRST lasted 1 cycle
    add(0, 0, 1, 0, 0, O_ISO);
    add(0, 0, 1, 0, 0, O_RST);
    add(0, 0, 0, 0, 0, O_PWRDN);
    add(0, 0, 0, 0, 0, O_OFF);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].ack,
           vecs[i].st, vecs[i].iv, vecs[i].exp);

    // PWRUP acknowledge timeout: FAULT 4 cycles after PWRUP entry.
    step("to_rst", 1, 0, 0, 2, 1, O_OFF);
    step("to_up0", 0, 1, 0, 2, 1, O_PWRUP);
    for (int i = 1; i < 4; i++)
      step($sformatf("to_up%0d", i), 0, 1, 0, 2, 1, O_PWRUP);
    step("to_fault", 0, 1, 0, 2, 1, O_FAULT);
    step("to_sticky0", 0, 0, 0, 2, 1, O_FAULT);
    step("to_sticky1", 0, 1, 1, 2, 1, O_FAULT);
    step("to_sticky2", 0, 0, 1, 2, 1, O_FAULT);
    step("to_clear", 1, 0, 0, 2, 1, O_OFF);

    // Reset pulsed mid-UNRST.
    step("ur_up", 0, 1, 0, 2, 1, O_PWRUP);
    step("ur_settle0", 0, 1, 1, 2, 1, O_SETTLE);
    step("ur_settle1", 0, 1, 1, 2, 1, O_SETTLE);
    step("ur_settle2", 0, 1, 1, 2, 1, O_SETTLE);
    step("ur_unrst", 0, 1, 1, 2, 1, O_UNRST);
    step("ur_reset", 1, 1, 1, 2, 1, O_OFF);
    step("ur_after", 0, 0, 1, 2, 1, O_OFF);

    // PWRDN acknowledge timeout: rail never drops.
    step("pd_up", 0, 1, 1, 0, 0, O_PWRUP);
    step("pd_settle", 0, 1, 1, 0, 0, O_SETTLE);
    step("pd_unrst", 0, 1, 1, 0, 0, O_UNRST);
    step("pd_on", 0, 1, 1, 0, 0, O_ON);
    step("pd_iso", 0, 0, 1, 0, 0, O_ISO);
    step("pd_rst", 0, 0, 1, 0, 0, O_RST);
    for (int i = 0; i < 4; i++)
      step($sformatf("pd_dn%0d", i), 0, 0, 1, 0, 0, O_PWRDN);
    step("pd_fault", 0, 0, 1, 0, 0, O_FAULT);
    step("pd_clear", 1, 0, 1, 0, 0, O_OFF);

    // Randomised idle cycles in OFF with pwr_req low.
    for (int i = 0; i < 5; i++)
      step($sformatf("idle%0d", i), 0, 0, 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), O_OFF);

    inv_en = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
